// File: rtl/fma_pkg.sv
// fma_pkg: shared widths, the exponent bias and the pipeline payload types for the FMA align/add stage
package fma_pkg;
  localparam int EXP_W  = 10;
  localparam int PROD_W = 48;
  localparam int FRM_W  = 51;
  localparam int LZC_W  = 6;
  localparam int BIAS   = 127;
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [FRM_W-1:0] mant;
    logic             sticky;
    logic             zero;
    logic [LZC_W-1:0] lzc;
  } fma_sum_t;
  typedef struct packed {
    logic             ref_sign;
    logic             oth_sign;
    logic [EXP_W-1:0] exp;
    logic [FRM_W-1:0] ref_m;
    logic [FRM_W-1:0] oth_m;
    logic             sticky;
  } fma_align_t;
  function automatic logic [EXP_W-1:0] prod_exp_of(input logic [7:0] ea, input logic [7:0] eb);
    return EXP_W'(ea) + EXP_W'(eb) - EXP_W'(BIAS);
  endfunction
endpackage

// File: rtl/fma_lzc.sv
// fma_lzc: combinational leading-zero count of a sum frame from its MSB; reports FRM_W for an all-zero frame
//   mant_i  frame to inspect
//   lzc_o   number of zeros above the highest set bit
module fma_lzc
  import fma_pkg::*;
(
  input  logic [FRM_W-1:0] mant_i,
  output logic [LZC_W-1:0] lzc_o
);
  always_comb begin
    lzc_o = LZC_W'(FRM_W);
    for (int i = 0; i < FRM_W; i++) lzc_o = mant_i[i] ? LZC_W'(FRM_W - 1 - i) : lzc_o;
  end
endmodule

// File: rtl/fma_align_add.sv
// fma_align_add: aligns the 48-bit product against addend C and adds/subtracts them in a 2-stage valid/ready pipeline
//   in_valid/in_ready    input beat handshake (prod_*, c_*)
//   out_valid/out_ready  result handshake (sum_*): sign-magnitude 51-bit frame, exponent, sticky, zero flag, lzc
module fma_align_add
  import fma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              prod_sign,
  input  logic [EXP_W-1:0]  prod_exp,
  input  logic [PROD_W-1:0] prod_mant,
  input  logic              c_sign,
  input  logic [7:0]        c_exp,
  input  logic [23:0]       c_mant,
  input  logic              c_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sum_sign,
  output logic [EXP_W-1:0]  sum_exp,
  output logic [FRM_W-1:0]  sum_mant,
  output logic              sum_sticky,
  output logic              sum_zero,
  output logic [LZC_W-1:0]  sum_lzc
);
  fma_align_t s1_d, s1_q;
  fma_sum_t   s2_d, s2_q;
  logic       s1_v_q, s2_v_q, s2_en;
  logic signed [EXP_W:0] d;
  logic [EXP_W:0]   sh;
  logic [FRM_W-1:0] p_frm, c_frm, oth, shifted, mag;
  logic             p_ref, big, lost, sub, neg;
  logic [LZC_W-1:0] lzc;
  assign s2_en    = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s2_en;
  // Both frames put the binary point between bits 48 and 47.
  always_comb begin
    p_frm   = {1'b0, prod_mant, 2'b0};
    c_frm   = c_zero ? '0 : {2'b0, c_mant, 25'b0};
    d       = {prod_exp[EXP_W-1], prod_exp} - {3'b0, c_exp};
    p_ref   = (prod_mant != '0) && (c_zero || !d[EXP_W]);
    sh      = d[EXP_W] ? EXP_W'(-d) + '0 : d;
    oth     = p_ref ? c_frm : p_frm;
    big     = sh >= (EXP_W+1)'(FRM_W);
    shifted = big ? '0 : oth >> sh[LZC_W-1:0];
    lost    = big ? |oth : |(oth & ~({FRM_W{1'b1}} << sh[LZC_W-1:0]));
    s1_d    = '{ref_sign: p_ref ? prod_sign : c_sign,
                oth_sign: p_ref ? c_sign : prod_sign,
                exp:      p_ref ? prod_exp : {{(EXP_W-8){1'b0}}, c_exp},
                ref_m:    p_ref ? p_frm : c_frm,
                oth_m:    shifted | FRM_W'(lost),
                sticky:   lost};
  end
  // Subtraction keeps a magnitude: when the shifted operand wins, swap the operands and take its sign.
  always_comb begin
    sub  = s1_q.ref_sign ^ s1_q.oth_sign;
    neg  = sub && (s1_q.oth_m > s1_q.ref_m);
    mag  = !sub ? s1_q.ref_m + s1_q.oth_m : neg ? s1_q.oth_m - s1_q.ref_m : s1_q.ref_m - s1_q.oth_m;
    s2_d = '{sign:   (mag == '0) ? s1_q.ref_sign & s1_q.oth_sign : neg ? s1_q.oth_sign : s1_q.ref_sign,
             exp:    s1_q.exp,
             mant:   mag,
             sticky: s1_q.sticky,
             zero:   mag == '0,
             lzc:    lzc};
  end
  fma_lzc u_lzc (.mant_i(mag), .lzc_o(lzc));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      if (in_ready) s1_v_q <= in_valid;
      if (s2_en) s2_v_q <= s1_v_q;
      if (in_ready && in_valid) s1_q <= s1_d;
      if (s2_en && s1_v_q) s2_q <= s2_d;
    end
  assign out_valid  = s2_v_q;
  assign sum_sign   = s2_q.sign;
  assign sum_exp    = s2_q.exp;
  assign sum_mant   = s2_q.mant;
  assign sum_sticky = s2_q.sticky;
  assign sum_zero   = s2_q.zero;
  assign sum_lzc    = s2_q.lzc;
endmodule
